unpatchifier: RTL and testbench



---
 rtl/unpatchifier.sv | 162 ++++++++++++++++
 tb/tb_unpatchifier.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpatchifier.sv
// rtl/unpatchifier.sv - reassembles a patch-major pixel stream into a frame buffer and replays it in raster order
module unpatchifier #(
    parameter int CHANNEL_SIZE      = 8,
    parameter int NUM_CHANNELS      = 3,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH         = 16,
    parameter int IMG_HEIGHT        = 16,
    parameter int PATCH_SIZE        = 4,
    parameter int PATCH_SIZE_LOG2   = 2,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = PATCHES_IN_ROW * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   output_taken,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic [2:0]             state,
    output logic                   err
);

    localparam int PATCH_ROWS = TOTAL_NUM_PATCHES / PATCHES_IN_ROW;
    localparam int PR_W       = (PATCH_ROWS > 1) ? $clog2(PATCH_ROWS) : 1;
    localparam int PC_W       = (PATCHES_IN_ROW > 1) ? $clog2(PATCHES_IN_ROW) : 1;
    localparam int POS_W      = 2 * PATCH_SIZE_LOG2;
    localparam int ROW_W      = $clog2(IMG_HEIGHT);
    localparam int COL_W      = $clog2(IMG_WIDTH);
    localparam int NUM_PIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W     = $clog2(NUM_PIX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // The patch index is kept as a (patch_row, patch_col) pair so no divider is needed
    logic [PR_W-1:0]  patch_row;
    logic [PC_W-1:0]  patch_col;
    logic [POS_W-1:0] pos;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;

    logic [PIXEL_WIDTH-1:0] buffer [NUM_PIX];

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_fire;
    logic              out_fire;
    logic              load_final;
    logic              drain_final;

    assign state    = state_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign load_final  = (patch_row == PR_W'(PATCH_ROWS - 1))
                      && (patch_col == PC_W'(PATCHES_IN_ROW - 1))
                      && (pos == POS_W'(PATCH_VECTOR_SIZE - 1));
    assign drain_final = (r == ROW_W'(IMG_HEIGHT - 1)) && (c == COL_W'(IMG_WIDTH - 1));

    // PATCH_SIZE is a power of two, so patch base plus offset is a plain concatenation
    assign wr_addr = ADDR_W'({patch_row, pos[POS_W-1:PATCH_SIZE_LOG2]}) * ADDR_W'(IMG_WIDTH)
                   + ADDR_W'({patch_col, pos[PATCH_SIZE_LOG2-1:0]});
    assign rd_addr = ADDR_W'(r) * ADDR_W'(IMG_WIDTH) + ADDR_W'(c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_final) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && drain_final) state_d = DONE;
            end
            DONE: begin
                if (output_taken) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (state_q == DONE && output_taken)) begin
            patch_row <= '0;
            patch_col <= '0;
            pos       <= '0;
            r         <= '0;
            c         <= '0;
        end else begin
            if (in_fire) begin
                if (pos == POS_W'(PATCH_VECTOR_SIZE - 1)) begin
                    pos <= '0;
                    if (patch_col == PC_W'(PATCHES_IN_ROW - 1)) begin
                        patch_col <= '0;
                        patch_row <= (patch_row == PR_W'(PATCH_ROWS - 1)) ? '0 : patch_row + 1'b1;
                    end else begin
                        patch_col <= patch_col + 1'b1;
                    end
                end else begin
                    pos <= pos + 1'b1;
                end
            end
            if (out_fire) begin
                if (c == COL_W'(IMG_WIDTH - 1)) begin
                    c <= '0;
                    r <= (r == ROW_W'(IMG_HEIGHT - 1)) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    // in_last never alters the frame length; it only flags a framing mismatch
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state_q == IDLE && en) begin
            err <= 1'b0;
        end else if (in_fire && (in_last != load_final)) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && !reset) begin
            buffer[wr_addr] <= in_data;
        end
    end

    assign out_data = out_valid ? buffer[rd_addr] : '0;
    assign out_last = out_valid && drain_final;

endmodule

// File: tb/tb_unpatchifier.sv
// tb/tb_unpatchifier.sv - randomized self-checking bench for unpatchifier against a raster-mapping model
module tb_unpatchifier;

    localparam int PW   = 24;
    localparam int PS   = 4;
    localparam int IW   = 16;
    localparam int PIR  = IW / PS;
    localparam int NPIX = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          output_taken;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          out_last;
    logic [2:0]    state;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    logic [PW-1:0] exp_img    [NPIX];
    logic [PW-1:0] got        [NPIX];
    logic [PW-1:0] frame_data [NPIX];
    int            out_idx    = 0;
    int            rdy_cycles = 0;
    bit            mon_on     = 1'b0;
    int            out_mode   = 0;
    bit            stall      = 1'b0;
    logic [PW-1:0] prev_data;
    logic          prev_last;

    always #5 clk = ~clk;

    unpatchifier dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .output_taken (output_taken),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .state        (state),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raster position of input beat k: patch k/16 sits on a 4x4 grid of patches, pixel k%16 row-major inside it
    function automatic int raster_of(input int k);
        int p;
        int q;
        p = k / (PS * PS);
        q = k % (PS * PS);
        return ((p / PIR) * PS + q / PS) * IW + (p % PIR) * PS + q % PS;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (in_ready) rdy_cycles++;
                if (out_valid) begin
                    if (out_idx >= NPIX) begin
                        check("overrun", out_idx, NPIX - 1);
                    end else begin
                        check("out_data", out_data, exp_img[out_idx]);
                        check("out_last", out_last, 32'(out_idx == NPIX - 1));
                        got[out_idx] = out_data;
                    end
                    if (stall) begin
                        check("hold_data", out_data, prev_data);
                        check("hold_last", out_last, prev_last);
                    end
                    stall     = !out_ready;
                    prev_data = out_data;
                    prev_last = out_last;
                    if (out_ready) out_idx++;
                end else begin
                    check("idle_data", out_data, 0);
                    check("idle_last", out_last, 0);
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic start_frame();
        out_idx    = 0;
        rdy_cycles = 0;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("load_latency", state, 1);
        check("ready_latency", in_ready, 1);
    endtask

    task automatic load_frame(input int pattern, input int vmode, input int last_at, input int abort_after);
        int k      = 0;
        int budget = 0;
        bit fire;
        for (int i = 0; i < NPIX; i++) begin
            if (pattern == 0)      frame_data[i] = PW'(i);
            else if (pattern == 1) frame_data[i] = PW'(255 - i);
            else                   frame_data[i] = PW'($urandom);
            if (abort_after < 0) exp_img[raster_of(i)] = frame_data[i];
        end
        while (k < NPIX && (abort_after < 0 || k < abort_after) && budget < 4000) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (budget % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = frame_data[k];
            in_last = (k == last_at);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) k++;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (budget >= 4000) begin
            check("load_timeout", k, NPIX);
        end else if (abort_after < 0) begin
            check("in_ready_drop", in_ready, 0);
            check("out_valid_rise", out_valid, 1);
        end
    endtask

    task automatic wait_done(input bit poke_en);
        int budget = 0;
        int pokes  = 0;
        while (state !== 3'd3 && budget < 3000) begin
            if (poke_en && state == 3'd2 && pokes < 4) begin
                en = 1'b1;
                pokes++;
            end else begin
                en = 1'b0;
            end
            @(posedge clk);
            #1;
            budget++;
            if (en) check("en_in_drain", state, 2);
        end
        en = 1'b0;
        check("done_reached", state, 3);
    endtask

    task automatic finish_frame(input bit exp_err, input int hold);
        check("err_done", err, 32'(exp_err));
        check("drained", out_idx, NPIX);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("done_hold", state, 3);
        end
        output_taken = 1'b1;
        @(posedge clk);
        #1;
        output_taken = 1'b0;
        check("back_to_idle", state, 0);
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        output_taken = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        mon_on = 1'b1;

        check("model_r4", raster_of(16), 4);
        check("model_r81", raster_of(69), 81);
        check("model_r255", raster_of(255), 255);
        repeat (3) @(posedge clk);
        #1;
        check("idle_stays", state, 0);

        // Straight-through frame
        out_mode = 0;
        start_frame();
        load_frame(0, 0, 255, -1);
        wait_done(1'b0);
        check("ready_cycles", rdy_cycles, NPIX);
        check("raster4", got[4], 16);
        check("raster81", got[81], 69);
        check("raster255", got[255], 255);
        finish_frame(1'b0, 0);

        // Stalls on both sides
        out_mode = 1;
        start_frame();
        load_frame(0, 1, 255, -1);
        wait_done(1'b0);
        finish_frame(1'b0, 0);

        // Misplaced in_last, then a long wait in DONE
        out_mode = 0;
        start_frame();
        load_frame(0, 0, 100, -1);
        wait_done(1'b0);
        finish_frame(1'b1, 10);

        // Inverted pattern with ignored output_taken in LOAD and ignored en in DRAIN
        start_frame();
        check("err_clear", err, 0);
        output_taken = 1'b1;
        load_frame(1, 0, 255, -1);
        output_taken = 1'b0;
        check("taken_in_load", state, 2);
        wait_done(1'b1);
        finish_frame(1'b0, 0);

        // Reset mid-load, then a full frame
        start_frame();
        load_frame(0, 0, 255, 37);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_state", state, 0);
        check("abort_ready", in_ready, 0);
        start_frame();
        load_frame(0, 0, 255, -1);
        wait_done(1'b0);
        check("abort_raster81", got[81], 69);
        finish_frame(1'b0, 0);

        // Random data with random back-pressure on both sides
        out_mode = 2;
        start_frame();
        load_frame(2, 2, 255, -1);
        wait_done(1'b0);
        finish_frame(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
